// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with r0 hardwired to zero, optional write-to-read
// bypass, and a per-register pending scoreboard with a running pending count.
module regfile_sb #(
    parameter int WIDTH  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             we_i,
    input  logic [AW-1:0]    wa_i,
    input  logic [WIDTH-1:0] wd_i,
    input  logic [AW-1:0]    ra1_i,
    input  logic [AW-1:0]    ra2_i,
    output logic [WIDTH-1:0] rd1_o,
    output logic [WIDTH-1:0] rd2_o,
    input  logic             iss_en_i,
    input  logic [AW-1:0]    iss_wa_i,
    input  logic             flush_i,
    output logic             busy1_o,
    output logic             busy2_o,
    output logic [AW:0]      pend_cnt_o
);
    localparam int N = 1 << AW;
    logic [WIDTH-1:0] regs_q [N];
    logic [N-1:0]     pend_q, pend_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr, iss, inc, dec, hit1, hit2;
    assign wr   = we_i && wa_i != '0;
    assign iss  = iss_en_i && iss_wa_i != '0;
    assign inc  = iss && !pend_q[iss_wa_i];
    // A clear that coincides with a re-issue of the same register is not a clear.
    assign dec  = wr && pend_q[wa_i] && !(iss && iss_wa_i == wa_i);
    assign hit1 = BYPASS != 0 && we_i && wa_i == ra1_i;
    assign hit2 = BYPASS != 0 && we_i && wa_i == ra2_i;
    always_comb begin
        pend_d = pend_q;
        if (wr) pend_d[wa_i] = 1'b0;
        if (iss) pend_d[iss_wa_i] = 1'b1;
        if (flush_i) pend_d = '0;
        pend_d[0] = 1'b0;
        cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
    end
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int i = 0; i < N; i++) regs_q[i] <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr) regs_q[wa_i] <= wd_i;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end
    always_comb begin
        rd1_o   = ra1_i == '0 ? '0 : hit1 ? wd_i : regs_q[ra1_i];
        rd2_o   = ra2_i == '0 ? '0 : hit2 ? wd_i : regs_q[ra2_i];
        busy1_o = pend_q[ra1_i] && !hit1;
        busy2_o = pend_q[ra2_i] && !hit2;
    end
    assign pend_cnt_o = cnt_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of a BYPASS=1 and a BYPASS=0 regfile_sb driven in lockstep.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        reset, we, iss_en, flush;
    logic [4:0]  wa, ra1, ra2, iss_wa;
    logic [31:0] wd;
    logic [31:0] rd1_b1, rd2_b1, rd1_b0, rd2_b0;
    logic        busy1_b1, busy2_b1, busy1_b0, busy2_b0;
    logic [5:0]  cnt_b1, cnt_b0;
    int          ncmp = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    regfile_sb #(.WIDTH(32), .AW(5), .BYPASS(1)) u_b1 (
        .clk_i(clk), .reset_i(reset), .we_i(we), .wa_i(wa), .wd_i(wd),
        .ra1_i(ra1), .ra2_i(ra2), .rd1_o(rd1_b1), .rd2_o(rd2_b1),
        .iss_en_i(iss_en), .iss_wa_i(iss_wa), .flush_i(flush),
        .busy1_o(busy1_b1), .busy2_o(busy2_b1), .pend_cnt_o(cnt_b1)
    );
    regfile_sb #(.WIDTH(32), .AW(5), .BYPASS(0)) u_b0 (
        .clk_i(clk), .reset_i(reset), .we_i(we), .wa_i(wa), .wd_i(wd),
        .ra1_i(ra1), .ra2_i(ra2), .rd1_o(rd1_b0), .rd2_o(rd2_b0),
        .iss_en_i(iss_en), .iss_wa_i(iss_wa), .flush_i(flush),
        .busy1_o(busy1_b0), .busy2_o(busy2_b0), .pend_cnt_o(cnt_b0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; iss_en = 1'b0; flush = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF;
        iss_en = 1'b1; iss_wa = 5'd4; flush = 1'b0; ra1 = 5'd3; ra2 = 5'd4;
        tick(); tick();
        reset = 1'b1; idle();
        chk("rst_rd1_b1", rd1_b1, 0);
        chk("rst_rd1_b0", rd1_b0, 0);
        chk("rst_busy2_b1", 32'(busy2_b1), 0);
        chk("rst_cnt_b1", 32'(cnt_b1), 0);
        chk("rst_cnt_b0", 32'(cnt_b0), 0);

        we = 1'b1; wa = 5'd5; wd = 32'h12345678; tick();
        wa = 5'd0; wd = 32'hFFFFFFFF; tick();
        idle(); ra1 = 5'd5; ra2 = 5'd0; #1;
        chk("wr_r5_b1", rd1_b1, 32'h12345678);
        chk("wr_r5_b0", rd1_b0, 32'h12345678);
        chk("wr_r0_b1", rd2_b1, 0);
        chk("wr_r0_b0", rd2_b0, 0);
        chk("wr_cnt", 32'(cnt_b1), 0);

        we = 1'b1; wa = 5'd7; wd = 32'h11; tick();
        wd = 32'h22; ra1 = 5'd7; #1;
        chk("byp_pre_b1", rd1_b1, 32'h22);
        chk("byp_pre_b0", rd1_b0, 32'h11);
        tick(); idle();
        chk("byp_post_b1", rd1_b1, 32'h22);
        chk("byp_post_b0", rd1_b0, 32'h22);
        chk("byp_cnt", 32'(cnt_b1), 0);

        iss_en = 1'b1; iss_wa = 5'd9; #1;
        ra1 = 5'd9; #1;
        chk("iss_same_cyc_busy", 32'(busy1_b1), 0);
        tick(); idle();
        chk("sb_busy_b1", 32'(busy1_b1), 1);
        chk("sb_busy_b0", 32'(busy1_b0), 1);
        chk("sb_cnt_b1", 32'(cnt_b1), 1);
        chk("sb_cnt_b0", 32'(cnt_b0), 1);
        we = 1'b1; wa = 5'd9; wd = 32'h99; #1;
        chk("sb_mask_b1", 32'(busy1_b1), 0);
        chk("sb_nomask_b0", 32'(busy1_b0), 1);
        chk("sb_fwd_b1", rd1_b1, 32'h99);
        tick(); idle();
        chk("sb_clr_cnt_b1", 32'(cnt_b1), 0);
        chk("sb_clr_cnt_b0", 32'(cnt_b0), 0);
        chk("sb_clr_busy_b0", 32'(busy1_b0), 0);

        iss_en = 1'b1; iss_wa = 5'd9; tick();
        we = 1'b1; wa = 5'd9; tick(); idle();
        chk("sim_set_wins_busy", 32'(busy1_b0), 1);
        chk("sim_set_wins_cnt", 32'(cnt_b1), 1);
        iss_en = 1'b1; iss_wa = 5'd10; we = 1'b1; wa = 5'd9; tick(); idle();
        ra2 = 5'd10; #1;
        chk("move_busy9", 32'(busy1_b1), 0);
        chk("move_busy10", 32'(busy2_b1), 1);
        chk("move_cnt_b1", 32'(cnt_b1), 1);
        chk("move_cnt_b0", 32'(cnt_b0), 1);
        iss_en = 1'b1; iss_wa = 5'd0; tick(); idle();
        ra1 = 5'd0; #1;
        chk("iss_r0_cnt", 32'(cnt_b1), 1);
        chk("iss_r0_busy", 32'(busy1_b1), 0);

        we = 1'b1; wa = 5'd10; wd = 32'hA; tick(); idle();
        chk("wb10_cnt", 32'(cnt_b1), 0);
        for (int r = 1; r <= 3; r++) begin
            iss_en = 1'b1; iss_wa = 5'(r); tick();
        end
        idle();
        chk("three_cnt_b1", 32'(cnt_b1), 3);
        chk("three_cnt_b0", 32'(cnt_b0), 3);
        flush = 1'b1; iss_en = 1'b1; iss_wa = 5'd4; tick(); idle();
        for (int r = 1; r <= 4; r += 2) begin
            ra1 = 5'(r); ra2 = 5'(r + 1); #1;
            chk($sformatf("flush_busy_r%0d", r), 32'(busy1_b1), 0);
            chk($sformatf("flush_busy_r%0d", r + 1), 32'(busy2_b0), 0);
        end
        chk("flush_cnt_b1", 32'(cnt_b1), 0);
        chk("flush_cnt_b0", 32'(cnt_b0), 0);

        iss_en = 1'b1; iss_wa = 5'd1; tick(); idle();
        chk("reiss_cnt", 32'(cnt_b1), 1);
        reset = 1'b0; tick();
        reset = 1'b1; #1;
        chk("rst2_cnt_b1", 32'(cnt_b1), 0);
        chk("rst2_cnt_b0", 32'(cnt_b0), 0);
        ra2 = 5'd1; #1;
        chk("rst2_busy_r1", 32'(busy2_b1), 0);
        for (int r = 0; r < 32; r++) begin
            ra1 = 5'(r); #1;
            chk($sformatf("rst2_rd_r%0d", r), rd1_b1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file for the pipelined MIPS datapath, replacing the fixed 32x32 flop register file.
- Provides two combinational read ports, one write port, and optional write-to-read bypass. Register 0 is hardwired to zero.
- Includes a per-register pending scoreboard: an instruction marks its destination busy at issue, and the busy bit clears at writeback. The decode stage uses the busy flags to stall.

Parameters:
- WIDTH, 32: data width of each register.
- AW, 5: address width; the file holds 2^AW registers.
- BYPASS, 1: 1 enables same-cycle write-to-read forwarding and busy masking; 0 disables both.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low; reset==0 at posedge clk resets all state.
- we  input  1  writeback enable.
- wa  input  AW  writeback address.
- wd  input  WIDTH  writeback data.
- ra1  input  AW  read address, port 1.
- ra2  input  AW  read address, port 2.
- rd1  output  WIDTH  read data, port 1 (combinational).
- rd2  output  WIDTH  read data, port 2 (combinational).
- iss_en  input  1  issue: mark iss_wa pending.
- iss_wa  input  AW  destination register being issued.
- flush  input  1  clear all pending bits (pipeline squash).
- busy1  output  1  register ra1 is pending (combinational).
- busy2  output  1  register ra2 is pending (combinational).
- pend_cnt  output  AW+1  number of pending registers (registered).

Behaviour:
- Interface:
  - One clock; reset is synchronous and active-low.
  - All sequential logic is triggered by posedge clk only. reset is sampled only at the edge.
- Reset (reset==0 at the edge):
  - All registers become 0, all pending bits become 0, pend_cnt becomes 0.
  - we, iss_en and flush are ignored in that cycle.
  - After reset, rd1/rd2 read 0 for every address and busy1/busy2 are 0.
- Write:
  - If we && wa!=0 at the edge, R[wa] <= wd. Writes to address 0 are discarded.
- Read:
  - rd = 0 when ra==0.
  - Else if BYPASS && we && wa==ra, rd = wd (same-cycle forwarding).
  - Else rd = R[ra].
  - Both ports resolve independently; ra1==ra2 is legal.
- Pending bits, per register r != 0, next state in priority order:
  - flush: 0.
  - else iss_en && iss_wa==r: 1. Set wins over a simultaneous clear, because it belongs to a younger instruction.
  - else we && wa==r: 0.
  - else: hold.
  - Pending bit 0 is constant 0; issue to address 0 is ignored.
  - Writeback to a non-pending register is legal, updates data, and leaves the bit at 0.
  - Issue to an already-pending register is legal; the bit stays 1 and there is no count change.
- busy outputs:
  - busy = pend[ra], masked to 0 when BYPASS && we && wa==ra, because the data is forwarded this cycle.
  - busy reflects current state only; an issue in this cycle does not affect busy until the next cycle.
- pend_cnt:
  - Equals the population count of the pending bits after each edge.
  - Implement it as an incrementally updated counter: +1 on a new set, -1 on a clear of a set bit, net 0 when both occur on different registers, 0 on flush.
  - The bench checks it against the popcount. It never exceeds 2^AW-1.
- BYPASS=0:
  - rd always returns stored R[ra].
  - busy is not masked by a same-cycle writeback.
- No internal latency beyond one edge for state; reads are zero-cycle.

Test Plan:
1. Reset value:
   - Stimulus: hold reset=0 for 2 edges with we=1, wa=3, wd=0xDEADBEEF, iss_en=1, iss_wa=4; then release.
   - Required: rd1 (ra1=3)=0, busy2 (ra2=4)=0, pend_cnt=0.
2. Write/read and register 0:
   - Stimulus: write 0x12345678 to r5, then write 0xFFFFFFFF to r0.
   - Required: ra1=5 gives 0x12345678; ra2=0 gives 0; no pending changes.
3. Bypass:
   - Stimulus: BYPASS=1, r7 holds 0x11; in the same cycle we=1, wa=7, wd=0x22, ra1=7.
   - Required: rd1=0x22 before the edge and 0x22 after.
   - Repeat with BYPASS=0: rd1=0x11 before the edge, 0x22 after.
4. Scoreboard set/clear:
   - Stimulus: issue r9; next cycle ra1=9.
   - Required: busy1=1, pend_cnt=1.
   - Stimulus: writeback r9 with ra1=9.
   - Required: busy1=0 in that cycle (BYPASS=1), and pend_cnt=0 after the edge.
5. Simultaneous events:
   - Stimulus: r9 pending; iss_en=1, iss_wa=9 together with we=1, wa=9.
   - Required: r9 stays pending, pend_cnt unchanged.
   - Stimulus: issue r10 while writing back r9.
   - Required: pend_cnt unchanged, busy moves from r9 to r10.
   - Stimulus: issue r0.
   - Required: pend_cnt unchanged.
6. Flush and reset mid-operation:
   - Stimulus: issue r1, r2, r3 so that pend_cnt=3; then flush=1 with iss_en=1, iss_wa=4.
   - Required: all busy=0, pend_cnt=0.
   - Stimulus: re-issue r1, then assert reset=0 for one edge.
   - Required: pend_cnt=0 and all registers read 0.
